iram_loadable: RTL and testbench
================================

// Module: iram_loadable
// PURPOSE
//  Next-generation instruction memory for the downsampling processor. Parametrised in width and depth.
//  Adds an in-system program-load port, so a new program can be written without resynthesis.
//  Every load is verified by read-back checksum. The processor is stalled (cpu_hold) while a load/verify runs.
//  Sits between the PC (addr) and the MBRU (dout), exactly like the fixed ROM it replaces; the load port is driven by the host/UART bridge.
// PARAMETERS
//  DATA_W   8      instruction word width (bits)
//  ADDR_W   8      address width (bits)
//  DEPTH    256    number of words implemented; must be <= 2**ADDR_W
//  OOR_WORD 8'd2   word returned for addr >= DEPTH (NOP opcode); width DATA_W
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  addr      in   ADDR_W    fetch address from PC
//  dout      out  DATA_W    registered instruction word to MBRU
//  rd_valid  out  1         dout holds the word for the addr sampled on the previous edge
//  ld_start  in   1         one-cycle pulse: begin load of ld_len words from address 0
//  ld_len    in   ADDR_W+1  word count, sampled on ld_start
//  ld_data   in   DATA_W    load word
//  ld_valid  in   1         ld_data valid
//  ld_ready  out  1         block accepts ld_data this cycle (word written when ld_valid&ld_ready)
//  ld_busy   out  1         load or verify in progress
//  ld_done   out  1         one-cycle pulse at end of load+verify (success or failure)
//  ld_err    out  1         sticky: last load failed; cleared by next accepted ld_start
//  checksum  out  DATA_W    sum mod 2**DATA_W of words written by the last load
//  cpu_hold  out  1         stall request to processor control unit (= ld_busy)
// BEHAVIOUR
//  Reset values
//   - dout=0, rd_valid=0, ld_ready=0, ld_busy=0, ld_done=0, ld_err=0, checksum=0, cpu_hold=0.
//   - FSM returns to IDLE.
//   - Memory array is not cleared (no reset on storage).
//  FSM: IDLE -> LOAD -> VERIFY -> DONE -> IDLE.
//  IDLE
//   - Each cycle: dout <= (addr<DEPTH) ? mem[addr] : OOR_WORD; rd_valid <= 1. Read latency is 1 cycle.
//   - ld_start with ld_len==0 or ld_len>DEPTH: ld_err<=1, ld_done pulses next cycle, no write, stay IDLE.
//   - ld_start with a valid length: latch len, wr_ptr=0, sum=0, ld_err<=0, go to LOAD.
//  LOAD
//   - ld_ready=1.
//   - On ld_valid: mem[wr_ptr]<=ld_data; sum+=ld_data (mod 2**DATA_W); wr_ptr++.
//   - When the word at wr_ptr==len-1 is accepted: checksum<=sum incl. that word, rd_ptr=0, go to VERIFY.
//   - ld_valid low stalls the load indefinitely; there is no timeout.
//  VERIFY
//   - ld_ready=0. Reads mem[0..len-1], one per cycle, through the same 1-cycle registered read.
//   - Accumulates vsum; takes len+1 cycles.
//   - vsum != checksum: ld_err<=1. Then go to DONE.
//  DONE
//   - ld_done=1 for exactly one cycle, then IDLE.
//  ld_busy / cpu_hold / rd_valid
//   - ld_busy=cpu_hold=1 in LOAD, VERIFY and DONE.
//   - rd_valid=0 from the cycle after ld_start until the first IDLE read completes.
//   - dout holds its last fetch value while busy and never shows verify data.
//  Other rules
//   - ld_start while busy is ignored. ld_valid outside LOAD is ignored.
//   - Fetch addr is ignored while busy.
//   - Async reset mid-load aborts immediately. Words already written remain; checksum=0, ld_err=0.
//   - Words beyond len keep their previous contents.
// TESTING
//  1. Reset, then ld_start len=4, data 03,13,0C,2A -> ld_ready 4 cycles; checksum=0x4C; ld_done after 5 verify cycles; ld_err=0; then addr=2 -> dout=0x0C one cycle later.
//  2. Load len=2, data FF,02 -> checksum wraps to 0x01; ld_err=0.
//  3. ld_start len=0, then len=257 (DEPTH=256) -> ld_err=1, ld_done one pulse each, memory unchanged, cpu_hold never high.
//  4. Load len=3 with ld_valid gaps of 2 cycles; ld_start pulse mid-load -> ignored; exactly 3 words written, cpu_hold high throughout.
//  5. DEPTH=200, ADDR_W=8: addr=250 -> dout=0x02 (OOR_WORD); addr=199 -> mem[199].
//  6. Assert rst_n=0 after 2 of 4 load words -> all outputs reset asynchronously; mem[0..1] hold new data; next load of len=4 succeeds.

Source files
------------

// File: rtl/iram_loadable.sv
// iram_loadable: instruction memory for the downsampling processor with an
// in-system program-load port. Fetches read through one registered read port;
// a load writes ld_len words from address 0 and then reads them back to check
// the checksum. The processor is held off (cpu_hold) while a load or verify runs.
module iram_loadable #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] OOR_WORD = DATA_W'(2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [DATA_W-1:0] checksum,
  output logic              cpu_hold
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // DEPTH and the constant one expressed at counter width, so all length
  // compares are done on equal-width operands.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  // Storage and its read register carry no reset so they map onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Memory port controls.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              addr_in_range;
  logic              start_ok;

  // Control and datapath state.
  state_t            state_q,     state_d;
  logic [ADDR_W:0]   len_q,       len_d;
  logic [ADDR_W:0]   wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W:0]   vcnt_q,      vcnt_d;
  logic [DATA_W-1:0] sum_q,       sum_d;
  logic [DATA_W-1:0] vsum_q,      vsum_d;
  logic [DATA_W-1:0] checksum_q,  checksum_d;
  logic              err_q,       err_d;
  logic              bad_start_q, bad_start_d;
  logic              rd_valid_q,  rd_valid_d;
  logic              oor_q,       oor_d;
  logic [DATA_W-1:0] dout_hold_q, dout_hold_d;

  // Verify sum including the word returning from the read register this cycle.
  logic [DATA_W-1:0] vsum_final;

  // Memory port steering: writes only while loading, reads follow the PC
  // except during verify, where the verify counter owns the read port.
  always_comb begin
    addr_in_range = ({1'b0, addr} < DEPTH_L);
    start_ok      = ld_start && (ld_len != '0) && (ld_len <= DEPTH_L);
    wr_en         = (state_q == S_LOAD) && ld_valid;
    wr_addr       = wr_ptr_q[ADDR_W-1:0];
    if (state_q == S_VERIFY) begin
      rd_addr = vcnt_q[ADDR_W-1:0];
    end else if (addr_in_range) begin
      rd_addr = addr;
    end else begin
      // Out-of-range fetches park on word 0; the OOR word is substituted at dout.
      rd_addr = '0;
    end
  end

  // Block RAM: synchronous write, registered read shared by fetch and verify.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= ld_data;
    end
    rdata_q <= mem[rd_addr];
  end

  // State register: every control flop, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      vcnt_q      <= '0;
      sum_q       <= '0;
      vsum_q      <= '0;
      checksum_q  <= '0;
      err_q       <= 1'b0;
      bad_start_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      oor_q       <= 1'b0;
      dout_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      vcnt_q      <= vcnt_d;
      sum_q       <= sum_d;
      vsum_q      <= vsum_d;
      checksum_q  <= checksum_d;
      err_q       <= err_d;
      bad_start_q <= bad_start_d;
      rd_valid_q  <= rd_valid_d;
      oor_q       <= oor_d;
      dout_hold_q <= dout_hold_d;
    end
  end

  // Next-state and datapath updates for IDLE -> LOAD -> VERIFY -> DONE.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    vcnt_d      = vcnt_q;
    sum_d       = sum_q;
    vsum_d      = vsum_q;
    checksum_d  = checksum_q;
    err_d       = err_q;
    bad_start_d = 1'b0;
    vsum_final  = vsum_q + rdata_q;

    // A fetch happens only in IDLE cycles that do not start a load; dout
    // keeps the last fetched word otherwise.
    rd_valid_d  = (state_q == S_IDLE) && !start_ok;
    oor_d       = !addr_in_range;
    dout_hold_d = dout;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          len_d    = ld_len;
          wr_ptr_d = '0;
          sum_d    = '0;
          err_d    = 1'b0;
          state_d  = S_LOAD;
        end else if (ld_start) begin
          // Zero or oversized length: flag and report, memory untouched.
          err_d       = 1'b1;
          bad_start_d = 1'b1;
        end
      end

      S_LOAD: begin
        if (ld_valid) begin
          sum_d    = sum_q + ld_data;
          wr_ptr_d = wr_ptr_q + ONE_L;
          if (wr_ptr_q == (len_q - ONE_L)) begin
            checksum_d = sum_q + ld_data;
            vcnt_d     = '0;
            vsum_d     = '0;
            state_d    = S_VERIFY;
          end
        end
      end

      S_VERIFY: begin
        // vcnt issues reads 0..len-1; data lands one cycle later, so the
        // sum completes on the cycle where vcnt equals len.
        vcnt_d = vcnt_q + ONE_L;
        if (vcnt_q != '0) begin
          vsum_d = vsum_final;
        end
        if (vcnt_q == len_q) begin
          if (vsum_final != checksum_q) begin
            err_d = 1'b1;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and registered flags.
  always_comb begin
    ld_ready = (state_q == S_LOAD);
    ld_busy  = (state_q != S_IDLE);
    cpu_hold = (state_q != S_IDLE);
    ld_done  = (state_q == S_DONE) || bad_start_q;
    ld_err   = err_q;
    checksum = checksum_q;
    rd_valid = rd_valid_q;
    if (rd_valid_q) begin
      dout = oor_q ? OOR_WORD : rdata_q;
    end else begin
      dout = dout_hold_q;
    end
  end

endmodule

// File: tb/tb_iram_loadable.sv
// Testbench for iram_loadable: a 256-word instance plus a 200-word instance
// share all stimulus; load checksums and fetch words are queued from a
// bench-side memory model and compared when the DUT produces them.
module tb_iram_loadable;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic       ld_start;
  logic [8:0] ld_len;
  logic [7:0] ld_data;
  logic       ld_valid;

  logic [7:0] dout, checksum;
  logic       rd_valid, ld_ready, ld_busy, ld_done, ld_err, cpu_hold;
  logic [7:0] dout_s, checksum_s;
  logic       rd_valid_s, ld_ready_s, ld_busy_s, ld_done_s, ld_err_s, cpu_hold_s;

  always #5 clk = ~clk;

  iram_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .OOR_WORD(8'd2)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .dout(dout), .rd_valid(rd_valid),
    .ld_start(ld_start), .ld_len(ld_len), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err),
    .checksum(checksum), .cpu_hold(cpu_hold)
  );

  iram_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .OOR_WORD(8'd2)) dut_s (
    .clk(clk), .rst_n(rst_n), .addr(addr), .dout(dout_s), .rd_valid(rd_valid_s),
    .ld_start(ld_start), .ld_len(ld_len), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ld_ready_s), .ld_busy(ld_busy_s), .ld_done(ld_done_s), .ld_err(ld_err_s),
    .checksum(checksum_s), .cpu_hold(cpu_hold_s)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl   [256];
  logic [7:0] mdl_s [200];
  logic [7:0] stim  [$];

  typedef struct packed {
    logic [7:0] cs;
    logic       err;
  } ld_exp_t;

  ld_exp_t    ld_q   [$];
  logic [7:0] rd_q   [$];
  logic [7:0] rd_s_q [$];

  // Present a fetch address and queue the words both instances should return.
  task automatic fetch_drive(input logic [7:0] a);
    addr = a;
    rd_q.push_back(mdl[a]);
    if (a < 8'd200) rd_s_q.push_back(mdl_s[a]);
    else            rd_s_q.push_back(8'h02);
    @(negedge clk);
  endtask

  // Start a load of stim[], feed words whenever ld_ready, optional gaps and a
  // stray ld_start inside a gap; queue the expected checksum.
  task automatic load_drive(input int gap, input bit mid_start,
                            output int ready_cycles, output int hold_low);
    int         len   = stim.size();
    logic [7:0] s     = 8'h00;
    int         idx   = 0;
    int         guard = 0;
    int         g     = 0;
    ld_exp_t    e;
    ld_start = 1'b1;
    ld_len   = 9'(len);
    for (int i = 0; i < len; i++) begin
      s      = s + stim[i];
      mdl[i] = stim[i];
      if (i < 200) mdl_s[i] = stim[i];
    end
    e.cs  = s;
    e.err = 1'b0;
    ld_q.push_back(e);
    @(negedge clk);
    ld_start     = 1'b0;
    ready_cycles = 0;
    hold_low     = 0;
    while (idx < len && guard < 2000) begin
      guard++;
      if (ld_ready === 1'b1) ready_cycles++;
      if (cpu_hold !== 1'b1) hold_low++;
      if (g > 0) begin
        ld_valid = 1'b0;
        g--;
        if (mid_start && g == 1) begin
          ld_start = 1'b1;
          ld_len   = 9'd2;
        end
      end else if (ld_ready === 1'b1) begin
        ld_valid = 1'b1;
        ld_data  = stim[idx];
        idx++;
        g = gap;
      end else begin
        ld_valid = 1'b0;
      end
      @(negedge clk);
      ld_start = 1'b0;
    end
    ld_valid = 1'b0;
  endtask

  // Count cycles until ld_done (bounded); cyc=-1 on timeout.
  task automatic wait_done(output int cyc, output int hold_low);
    cyc      = 0;
    hold_low = 0;
    while (ld_done !== 1'b1 && cyc < 1000) begin
      if (cpu_hold !== 1'b1) hold_low++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 1000) cyc = -1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    addr     = 8'h00;
    ld_start = 1'b0;
    ld_len   = 9'd0;
    ld_data  = 8'h00;
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_valid, ld_ready, ld_busy, ld_done, ld_err, cpu_hold} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000",
               {rd_valid, ld_ready, ld_busy, ld_done, ld_err, cpu_hold});
    end
    checks++;
    if (dout !== 8'h00 || checksum !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: dout=%h checksum=%h required 00/00", dout, checksum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_rd_valid: got %b required 1", rd_valid);
    end
    $display("reset: outputs cleared, rd_valid=%b after first idle cycle", rd_valid);
  endtask

  task automatic test_load_basic;
    int      rc, hl, cyc, hl2;
    ld_exp_t e;
    stim = '{8'h03, 8'h13, 8'h0C, 8'h2A};
    load_drive(0, 1'b0, rc, hl);
    checks++;
    if (rc != 4) begin
      failures++;
      $display("FAIL basic_ready_cycles: got %0d required 4", rc);
    end
    wait_done(cyc, hl2);
    checks++;
    if (cyc != 5) begin
      failures++;
      $display("FAIL basic_verify_cycles: got %0d required 5", cyc);
    end
    e = ld_q.pop_front();
    checks++;
    if (checksum !== e.cs || checksum !== 8'h4C || ld_err !== e.err) begin
      failures++;
      $display("FAIL basic_checksum: got %h err=%b required %h err=%b", checksum, ld_err, e.cs, e.err);
    end
    checks++;
    if (hl != 0 || hl2 != 0) begin
      failures++;
      $display("FAIL basic_cpu_hold: low cycles %0d/%0d required 0", hl, hl2);
    end
    @(negedge clk);
    checks++;
    if (ld_done !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: ld_done=%b cpu_hold=%b required 0/0", ld_done, cpu_hold);
    end
    $display("load len=4 checksum=%h err=%b verify_cycles=%0d", checksum, ld_err, cyc);
    fetch_drive(8'd2);
    void'(rd_s_q.pop_front());
    checks++;
    if (dout !== rd_q.pop_front() || dout !== 8'h0C || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_fetch2: got %h valid=%b required 0c valid=1", dout, rd_valid);
    end
    $display("fetch addr=02 dout=%h", dout);
  endtask

  task automatic test_wrap;
    int      rc, hl, cyc, hl2;
    ld_exp_t e;
    stim = '{8'hFF, 8'h02};
    load_drive(0, 1'b0, rc, hl);
    wait_done(cyc, hl2);
    e = ld_q.pop_front();
    checks++;
    if (checksum !== e.cs || checksum !== 8'h01 || ld_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_checksum: got %h err=%b required 01 err=0", checksum, ld_err);
    end
    checks++;
    if (cyc != 3) begin
      failures++;
      $display("FAIL wrap_verify_cycles: got %0d required 3", cyc);
    end
    checks++;
    if (dout !== 8'h0C || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_dout_hold: got %h valid=%b required 0c valid=0", dout, rd_valid);
    end
    $display("load len=2 checksum=%h err=%b verify_cycles=%0d", checksum, ld_err, cyc);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] exp_w;
      fetch_drive(8'(i));
      void'(rd_s_q.pop_front());
      exp_w = rd_q.pop_front();
      checks++;
      if (dout !== exp_w) begin
        failures++;
        $display("FAIL wrap_fetch: addr=%0d got %h required %h", i, dout, exp_w);
      end
      $display("fetch addr=%02h dout=%h", i, dout);
    end
  endtask

  task automatic test_bad_len;
    logic [8:0] lens [2];
    lens[0] = 9'd0;
    lens[1] = 9'd257;
    for (int k = 0; k < 2; k++) begin
      ld_start = 1'b1;
      ld_len   = lens[k];
      @(negedge clk);
      ld_start = 1'b0;
      checks++;
      if (ld_done !== 1'b1 || ld_err !== 1'b1 || cpu_hold !== 1'b0) begin
        failures++;
        $display("FAIL badlen_pulse: len=%0d done=%b err=%b hold=%b required 1/1/0",
                 lens[k], ld_done, ld_err, cpu_hold);
      end
      @(negedge clk);
      checks++;
      if (ld_done !== 1'b0 || cpu_hold !== 1'b0 || ld_err !== 1'b1) begin
        failures++;
        $display("FAIL badlen_after: len=%0d done=%b hold=%b err=%b required 0/0/1",
                 lens[k], ld_done, cpu_hold, ld_err);
      end
      $display("bad start len=%0d err=%b", lens[k], ld_err);
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_w;
      fetch_drive(8'(i));
      void'(rd_s_q.pop_front());
      exp_w = rd_q.pop_front();
      checks++;
      if (dout !== exp_w || cpu_hold !== 1'b0) begin
        failures++;
        $display("FAIL badlen_mem: addr=%0d got %h hold=%b required %h hold=0", i, dout, cpu_hold, exp_w);
      end
      $display("fetch addr=%02h dout=%h", i, dout);
    end
  endtask

  task automatic test_gaps;
    int      rc, hl, cyc, hl2;
    ld_exp_t e;
    stim = '{8'h5A, 8'hA5, 8'h33};
    load_drive(2, 1'b1, rc, hl);
    wait_done(cyc, hl2);
    e = ld_q.pop_front();
    checks++;
    if (checksum !== e.cs || ld_err !== 1'b0) begin
      failures++;
      $display("FAIL gaps_checksum: got %h err=%b required %h err=0", checksum, ld_err, e.cs);
    end
    checks++;
    if (cyc != 4) begin
      failures++;
      $display("FAIL gaps_verify_cycles: got %0d required 4", cyc);
    end
    checks++;
    if (hl != 0 || hl2 != 0) begin
      failures++;
      $display("FAIL gaps_cpu_hold: low cycles %0d/%0d required 0", hl, hl2);
    end
    $display("load len=3 gaps=2 checksum=%h err=%b verify_cycles=%0d", checksum, ld_err, cyc);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_w;
      fetch_drive(8'(i));
      void'(rd_s_q.pop_front());
      exp_w = rd_q.pop_front();
      checks++;
      if (dout !== exp_w) begin
        failures++;
        $display("FAIL gaps_fetch: addr=%0d got %h required %h", i, dout, exp_w);
      end
      $display("fetch addr=%02h dout=%h", i, dout);
    end
  endtask

  task automatic test_reset_midload;
    int      rc, hl, cyc, hl2;
    ld_exp_t e;
    ld_start = 1'b1;
    ld_len   = 9'd4;
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 8'h11;
    @(negedge clk);
    ld_data  = 8'h22;
    @(negedge clk);
    ld_valid = 1'b0;
    mdl[0] = 8'h11; mdl_s[0] = 8'h11;
    mdl[1] = 8'h22; mdl_s[1] = 8'h22;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_valid, ld_ready, ld_busy, ld_done, ld_err, cpu_hold} !== 6'b0 ||
        checksum !== 8'h00 || dout !== 8'h00) begin
      failures++;
      $display("FAIL midreset_async: flags=%b checksum=%h dout=%h required 000000/00/00",
               {rd_valid, ld_ready, ld_busy, ld_done, ld_err, cpu_hold}, checksum, dout);
    end
    $display("reset mid-load: busy=%b checksum=%h", ld_busy, checksum);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_w;
      fetch_drive(8'(i));
      void'(rd_s_q.pop_front());
      exp_w = rd_q.pop_front();
      checks++;
      if (dout !== exp_w) begin
        failures++;
        $display("FAIL midreset_mem: addr=%0d got %h required %h", i, dout, exp_w);
      end
      $display("fetch addr=%02h dout=%h", i, dout);
    end
    stim = '{8'h44, 8'h55, 8'h66, 8'h77};
    load_drive(0, 1'b0, rc, hl);
    wait_done(cyc, hl2);
    e = ld_q.pop_front();
    checks++;
    if (checksum !== e.cs || ld_err !== 1'b0 || cyc != 5) begin
      failures++;
      $display("FAIL midreset_reload: checksum=%h err=%b cycles=%0d required %h/0/5",
               checksum, ld_err, cyc, e.cs);
    end
    $display("load len=4 checksum=%h err=%b verify_cycles=%0d", checksum, ld_err, cyc);
    @(negedge clk);
  endtask

  task automatic test_oor;
    int         rc, hl, cyc, hl2;
    ld_exp_t    e;
    logic [7:0] exp_b, exp_s;
    stim.delete();
    for (int i = 0; i < 200; i++) stim.push_back(8'($urandom));
    load_drive(0, 1'b0, rc, hl);
    wait_done(cyc, hl2);
    e = ld_q.pop_front();
    checks++;
    if (checksum !== e.cs || checksum_s !== e.cs || ld_err !== 1'b0 || ld_err_s !== 1'b0 || cyc != 201) begin
      failures++;
      $display("FAIL oor_load: cs=%h cs_s=%h err=%b/%b cycles=%0d required %h err=0 cycles=201",
               checksum, checksum_s, ld_err, ld_err_s, cyc, e.cs);
    end
    $display("load len=200 checksum=%h err=%b verify_cycles=%0d", checksum, ld_err, cyc);
    @(negedge clk);
    fetch_drive(8'd250);
    void'(rd_q.pop_front());
    exp_s = rd_s_q.pop_front();
    checks++;
    if (dout_s !== exp_s || dout_s !== 8'h02 || rd_valid_s !== 1'b1) begin
      failures++;
      $display("FAIL oor_word: got %h valid=%b required 02 valid=1", dout_s, rd_valid_s);
    end
    $display("fetch depth200 addr=fa dout=%h", dout_s);
    fetch_drive(8'd199);
    exp_b = rd_q.pop_front();
    exp_s = rd_s_q.pop_front();
    checks++;
    if (dout_s !== exp_s || dout !== exp_b) begin
      failures++;
      $display("FAIL oor_last_word: got %h/%h required %h/%h", dout_s, dout, exp_s, exp_b);
    end
    $display("fetch addr=c7 dout_s=%h dout=%h", dout_s, dout);
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_wrap();
    test_bad_len();
    test_gaps();
    test_reset_midload();
    test_oor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
